pwm_seq_ctrl: RTL
=================

Name: pwm_seq_ctrl

Overview:
Sequencer that owns the 8-bit register bus of one pwm instance and replays a host-loaded table of pulse settings (Pl, Nl, Ph, Nh) at a programmable interval. Each entry is a burst of four single-cycle writes to pwm addresses 4..7.
The host also gets posted pass-through writes to any pwm register. These are arbitrated against sequencer writes, and the sequencer always has priority.
The block sits between the bus master and the pwm block.

Parameters:
DEPTH, 8, number of table entries; must be a power of two, 1..8.

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous active-low reset
address  in  4  host register address
databi  in  8  host write data
databo  out  8  host read data, registered
cen  in  1  host chip enable, sampled at posedge clk
wr  in  1  host write strobe, qualified by cen
pwm_address  out  3  pwm register address
pwm_databi  out  8  write data to pwm
pwm_cen  out  1  pwm chip enable
pwm_wr  out  1  pwm write strobe

Behaviour:
- Reset: all registers, table, FSM and outputs go to 0. FSM enters IDLE.
- pwm_* are registered on posedge clk, so they are stable when pwm samples them on negedge.
- A pwm transaction is pwm_cen=pwm_wr=1 for exactly one cycle. Otherwise pwm_cen=pwm_wr=0.
- Host access: registered at posedge when cen=1.
  - databo is updated the next cycle.
  - databo=0 when cen=0 or wr=1.
- Host register map:
  - 0 ID: reads 8'h02.
  - 1 CTRL: [7] run, [6] loop, [0] start. start is a write-1 pulse and reads 0.
  - 2 STATUS: [7] busy, [6] done, [5] ovf, [4] err, [3] pend, [2:0] idx. Bits 6..4 are sticky. Any write clears the sticky bits.
  - 3 IVL_LO, 4 IVL_HI: 16-bit interval IVL, in clocks.
  - 5 TPTR: table byte pointer, width log2(DEPTH)+2. Layout {entry, byte}, with byte 0..3 = Pl, Nl, Ph, Nh.
  - 6 TDATA: a write stores to table[TPTR] and increments TPTR, wrapping at 4*DEPTH. A read returns table[TPTR] without incrementing.
  - 7 LEN [3:0]: number of entries to play. Values above DEPTH are clamped to DEPTH.
  - 8..F: posted pwm write to pwm address address[2:0]. These addresses read 0.
- Posted write buffer: one deep; pend=1 while it is occupied.
  - A host write into a full buffer is dropped and sets ovf.
  - If the buffer drains in the same cycle, the new write is accepted.
  - The buffer is issued in the first cycle the FSM is not in LOAD. Latency is 1 cycle when the bus is free.
- FSM states:
  - IDLE:
    - A CTRL write with start=1 and run=1 sets idx=0, clears done and enters LOAD.
    - If LEN=0, the start is ignored and err is set.
    - start with run=0 is ignored.
  - LOAD:
    - Four consecutive cycles, bytes 0..3 of entry idx, sent to pwm addresses 4,5,6,7 in that order.
    - After byte 3: if IVL=0, advance; else enter WAIT with the counter cleared.
  - WAIT:
    - The counter increments each cycle. When counter+1 >= IVL, advance.
    - IVL is compared live. If IVL is lowered below the count, advance on the next cycle.
  - Advance:
    - If idx < LEN-1: idx+1, then LOAD.
    - Else if loop=1: idx=0, then LOAD.
    - Else: set done, go to IDLE.
  - Entry period is exactly 4+IVL cycles.
- busy=1 in any state other than IDLE.
- A start written while busy is ignored.
- Abort: a CTRL write with run=0 forces IDLE on the next edge.
  - Any partially loaded entry is left as-is in the pwm.
  - done is not set.
  - A posted write is unaffected.
- Table writes while busy are allowed and take effect when that entry is next loaded.
- Reset asserted mid-operation: FSM returns to IDLE and the pending buffer is discarded.

Test Plan:
1. Reset -> databo, pwm_cen, pwm_wr all 0; read of addr 0 returns 8'h02; STATUS reads 8'h00.
2. Load entry0 = {10,20,30,40} via TPTR=0 and 4 TDATA writes; LEN=1, IVL=0; write CTRL=8'h81 -> pwm writes addr 4..7 with data 10,20,30,40 on 4 consecutive cycles, first one the cycle after the CTRL write; then STATUS reads done=1, busy=0.
3. LEN=2, IVL=5, loop=1, start -> entry0 and entry1 load alternately with a period of 9 cycles; idx shows 0,1,0,…; writing CTRL=8'h00 returns FSM to IDLE on the next edge with no further pwm writes.
4. Host posted write to addr 9 (data 8'hA5) during WAIT -> pwm_address=1, pwm_databi=8'hA5 the next cycle. Same write issued during LOAD -> deferred until the LOAD burst finishes, pend=1 meanwhile; a second posted write while pend=1 -> ovf=1 and the second write is dropped.
5. LEN=0 then start -> err=1, busy stays 0, no pwm writes; a STATUS write clears err.
6. TPTR=4*DEPTH-1 followed by two TDATA writes -> the second write lands at byte 0 (pointer wrap); rst pulsed low during LOAD -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl_if
// Bundles the host register bus and the downstream pwm register bus seen by
// pwm_seq_ctrl.
//   address     [3:0]  host register address
//   databi      [7:0]  host write data
//   databo      [7:0]  host read data (registered in the sequencer)
//   cen, wr            host chip enable / write strobe
//   pwm_address [2:0]  pwm register address
//   pwm_databi  [7:0]  pwm write data
//   pwm_cen, pwm_wr    pwm chip enable / write strobe
// Modports: master = bus master (host), slave = sequencer, pwm = pwm block.
// -----------------------------------------------------------------------------
interface pwm_seq_ctrl_if;
    logic [3:0] address;
    logic [7:0] databi;
    logic [7:0] databo;
    logic       cen;
    logic       wr;
    logic [2:0] pwm_address;
    logic [7:0] pwm_databi;
    logic       pwm_cen;
    logic       pwm_wr;

    modport master (
        output address, databi, cen, wr,
        input  databo
    );

    modport slave (
        input  address, databi, cen, wr,
        output databo, pwm_address, pwm_databi, pwm_cen, pwm_wr
    );

    modport pwm (
        input pwm_address, pwm_databi, pwm_cen, pwm_wr
    );
endinterface

// File: rtl/pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl
// Owns the register bus of one pwm instance. Replays a host-loaded table of
// {Pl, Nl, Ph, Nh} entries as 4-write bursts to pwm addresses 4..7, one entry
// every 4+IVL clocks, and forwards host posted writes (addresses 8..F) to the
// pwm with lower priority than the sequencer.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  asynchronous active-low reset
//   bus  slave side of pwm_seq_ctrl_if (host bus in, databo and pwm_* out)
// -----------------------------------------------------------------------------
module pwm_seq_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_seq_ctrl_if.slave bus
);
    localparam int         PW      = $clog2(DEPTH) + 2;
    localparam int         TN      = 4 * DEPTH;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);
    localparam logic [7:0] ID_VAL  = 8'h02;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    // FSM state
    state_t        state_r, state_s, adv_state_s;
    logic [1:0]    byte_r, byte_s;
    logic [2:0]    idx_r, idx_s, adv_idx_s;
    logic [15:0]   cnt_r, cnt_s;
    logic          adv_done_s, set_done_s, clr_done_s, set_err_s;

    // host-visible registers
    logic          run_r, loop_r, done_r, ovf_r, err_r;
    logic [15:0]   ivl_r;
    logic [PW-1:0] tptr_r;
    logic [3:0]    len_r;
    logic [7:0]    tbl_r [TN];

    // posted write buffer and registered outputs
    logic          pend_r;
    logic [2:0]    pend_addr_r;
    logic [7:0]    pend_data_r;
    logic [7:0]    databo_r, rd_data_s;
    logic [2:0]    pwm_address_r;
    logic [7:0]    pwm_databi_r;
    logic          pwm_we_r;

    // host decode
    logic host_wr_s, host_rd_s, ctrl_wr_s, status_wr_s, tdata_wr_s, post_wr_s;
    logic start_s, abort_s, busy_s;
    logic seq_fire_s, drain_s, bypass_s, ovf_set_s, capture_s;
    logic [PW-1:0] seq_ptr_s;

    assign host_wr_s   = bus.cen & bus.wr;
    assign host_rd_s   = bus.cen & ~bus.wr;
    assign ctrl_wr_s   = host_wr_s & (bus.address == 4'd1);
    assign status_wr_s = host_wr_s & (bus.address == 4'd2);
    assign tdata_wr_s  = host_wr_s & (bus.address == 4'd6);
    assign post_wr_s   = host_wr_s & bus.address[3];
    assign start_s     = ctrl_wr_s & bus.databi[7] & bus.databi[0];
    assign abort_s     = ctrl_wr_s & ~bus.databi[7];
    assign busy_s      = (state_r != IDLE);

    // Sequencer wins the pwm bus whenever the next cycle is a LOAD cycle; the
    // buffer drains otherwise, and an incoming posted write with nothing ahead
    // of it goes straight through without occupying the buffer.
    assign seq_fire_s = (state_s == LOAD);
    assign seq_ptr_s  = PW'({idx_s, byte_s});
    assign drain_s    = pend_r & ~seq_fire_s;
    assign bypass_s   = post_wr_s & ~pend_r & ~seq_fire_s;
    assign ovf_set_s  = post_wr_s & pend_r & ~drain_s;
    assign capture_s  = post_wr_s & ~bypass_s & ~ovf_set_s;

    assign bus.databo      = databo_r;
    assign bus.pwm_address = pwm_address_r;
    assign bus.pwm_databi  = pwm_databi_r;
    assign bus.pwm_cen     = pwm_we_r;
    assign bus.pwm_wr      = pwm_we_r;

    // Where the sequencer goes once the current entry's period has elapsed.
    always_comb begin
        adv_state_s = IDLE;
        adv_idx_s   = idx_r;
        adv_done_s  = 1'b0;
        if (({1'b0, idx_r} + 4'd1) < len_r) begin
            adv_state_s = LOAD;
            adv_idx_s   = idx_r + 3'd1;
        end else if (loop_r) begin
            adv_state_s = LOAD;
            adv_idx_s   = 3'd0;
        end else begin
            adv_state_s = IDLE;
            adv_done_s  = 1'b1;
        end
    end

    // Next-state logic; an abort overrides whatever the FSM would do.
    always_comb begin
        state_s    = state_r;
        byte_s     = byte_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        set_done_s = 1'b0;
        clr_done_s = 1'b0;
        set_err_s  = 1'b0;
        if (abort_s) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s && (len_r == 4'd0)) begin
                        set_err_s = 1'b1;
                    end else if (start_s) begin
                        state_s    = LOAD;
                        byte_s     = 2'd0;
                        idx_s      = 3'd0;
                        clr_done_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: begin
                    if ((byte_r == 2'd3) && (ivl_r == 16'd0)) begin
                        state_s    = adv_state_s;
                        idx_s      = adv_idx_s;
                        byte_s     = 2'd0;
                        set_done_s = adv_done_s;
                    end else if (byte_r == 2'd3) begin
                        state_s = WAIT;
                        cnt_s   = 16'd0;
                    end else begin
                        byte_s = byte_r + 2'd1;
                    end
                end
                WAIT: begin
                    cnt_s = cnt_r + 16'd1;
                    // IVL is compared live so a lowered interval ends WAIT at once.
                    if (({1'b0, cnt_r} + 17'd1) >= {1'b0, ivl_r}) begin
                        state_s    = adv_state_s;
                        idx_s      = adv_idx_s;
                        byte_s     = 2'd0;
                        set_done_s = adv_done_s;
                    end else begin
                        state_s = WAIT;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            byte_r  <= 2'd0;
            idx_r   <= 3'd0;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            byte_r  <= byte_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    // Host configuration registers and sticky status bits (a set in the same
    // cycle as a clearing STATUS write wins so no event is lost).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_r  <= 1'b0;
            loop_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
            ivl_r  <= 16'd0;
            tptr_r <= '0;
            len_r  <= 4'd0;
        end else begin
            if (ctrl_wr_s) begin
                run_r  <= bus.databi[7];
                loop_r <= bus.databi[6];
            end
            if (set_done_s) begin
                done_r <= 1'b1;
            end else if (clr_done_s || status_wr_s) begin
                done_r <= 1'b0;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (status_wr_s) begin
                ovf_r <= 1'b0;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (status_wr_s) begin
                err_r <= 1'b0;
            end
            if (host_wr_s && (bus.address == 4'd3)) begin
                ivl_r[7:0] <= bus.databi;
            end
            if (host_wr_s && (bus.address == 4'd4)) begin
                ivl_r[15:8] <= bus.databi;
            end
            if (host_wr_s && (bus.address == 4'd5)) begin
                tptr_r <= bus.databi[PW-1:0];
            end else if (tdata_wr_s) begin
                tptr_r <= tptr_r + 1'b1;  // wraps naturally at 4*DEPTH
            end
            if (host_wr_s && (bus.address == 4'd7)) begin
                len_r <= (bus.databi[3:0] > DEPTH_L) ? DEPTH_L : bus.databi[3:0];
            end
        end
    end

    // Pulse table storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TN; i++) begin
                tbl_r[i] <= 8'h00;
            end
        end else if (tdata_wr_s) begin
            tbl_r[tptr_r] <= bus.databi;
        end
    end

    // Posted write buffer and the registered pwm bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r        <= 1'b0;
            pend_addr_r   <= 3'd0;
            pend_data_r   <= 8'h00;
            pwm_address_r <= 3'd0;
            pwm_databi_r  <= 8'h00;
            pwm_we_r      <= 1'b0;
        end else begin
            if (capture_s) begin
                pend_r      <= 1'b1;
                pend_addr_r <= bus.address[2:0];
                pend_data_r <= bus.databi;
            end else if (drain_s) begin
                pend_r <= 1'b0;
            end
            if (seq_fire_s) begin
                pwm_we_r      <= 1'b1;
                pwm_address_r <= {1'b1, byte_s};
                pwm_databi_r  <= tbl_r[seq_ptr_s];
            end else if (drain_s) begin
                pwm_we_r      <= 1'b1;
                pwm_address_r <= pend_addr_r;
                pwm_databi_r  <= pend_data_r;
            end else if (bypass_s) begin
                pwm_we_r      <= 1'b1;
                pwm_address_r <= bus.address[2:0];
                pwm_databi_r  <= bus.databi;
            end else begin
                pwm_we_r      <= 1'b0;
                pwm_address_r <= 3'd0;
                pwm_databi_r  <= 8'h00;
            end
        end
    end

    // Host read data mux.
    always_comb begin
        rd_data_s = 8'h00;
        case (bus.address)
            4'd0:    rd_data_s = ID_VAL;
            4'd1:    rd_data_s = {run_r, loop_r, 6'd0};
            4'd2:    rd_data_s = {busy_s, done_r, ovf_r, err_r, pend_r, idx_r};
            4'd3:    rd_data_s = ivl_r[7:0];
            4'd4:    rd_data_s = ivl_r[15:8];
            4'd5:    rd_data_s = 8'(tptr_r);
            4'd6:    rd_data_s = tbl_r[tptr_r];
            4'd7:    rd_data_s = {4'd0, len_r};
            default: rd_data_s = 8'h00;
        endcase
    end

    // Registered host read port; zero whenever no read is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            databo_r <= 8'h00;
        end else if (host_rd_s) begin
            databo_r <= rd_data_s;
        end else begin
            databo_r <= 8'h00;
        end
    end
endmodule
